pea_fifo_bank: RTL and testbench

PEA_FIFO_BANK -- requirements
Module: pea_fifo_bank

---
 rtl/pea_fifo_bank.sv | 101 ++++++++++
 tb/tb_pea_fifo_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pea_fifo_bank.sv
// Bank of CHANNELS FIFOs written in lockstep and read independently per lane.
// Optional sticky overflow/underflow flags are enabled by defining PEA_FIFO_BANK_ERR_EN.
module pea_fifo_bank #(
  parameter  int DEPTH    = 32,
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int PW       = AW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef PEA_FIFO_BANK_ERR_EN
  input  logic                      err_clr,
  output logic                      err_ovf,
  output logic [CHANNELS-1:0]       err_udf,
`endif
  input  logic                      wr_en,
  input  logic [CHANNELS-1:0]       rd_en,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS*PW-1:0]    population,
  output logic [CHANNELS*PW-1:0]    free_space,
  output logic [CHANNELS*WIDTH-1:0] data_out
);

  logic [CHANNELS-1:0] w_full;
  logic [CHANNELS-1:0] w_empty;
  logic [CHANNELS-1:0] w_rd_ok;
  logic                w_wr_ok;
  logic [AW-1:0]       r_wptr;

  // A write is all-or-nothing across lanes so the lanes never drift apart.
  assign w_wr_ok = wr_en & ~(|w_full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
    end else if (w_wr_ok) begin
      r_wptr <= r_wptr + AW'(1);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rptr;
    logic [PW-1:0]    r_pop;
    logic [WIDTH-1:0] r_dout;

    assign w_full[c]  = (r_pop == PW'(DEPTH));
    assign w_empty[c] = (r_pop == '0);
    assign w_rd_ok[c] = rd_en[c] & ~w_empty[c];

    // Storage is deliberately not reset; population alone defines validity.
    always_ff @(posedge clk) begin
      if (w_wr_ok) begin
        r_mem[r_wptr] <= data_in[c*WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_rptr <= '0;
        r_pop  <= '0;
        r_dout <= '0;
      end else begin
        if (w_rd_ok[c]) begin
          r_dout <= r_mem[r_rptr];
          r_rptr <= r_rptr + AW'(1);
        end
        case ({w_wr_ok, w_rd_ok[c]})
          2'b10:   r_pop <= r_pop + PW'(1);
          2'b01:   r_pop <= r_pop - PW'(1);
          default: r_pop <= r_pop;
        endcase
      end
    end

    assign population[c*PW +: PW]   = r_pop;
    assign free_space[c*PW +: PW]   = PW'(DEPTH) - r_pop;
    assign data_out[c*WIDTH +: WIDTH] = r_dout;
  end

`ifdef PEA_FIFO_BANK_ERR_EN
  logic                r_err_ovf;
  logic [CHANNELS-1:0] r_err_udf;

  // A new error event on the clearing edge takes priority over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= '0;
    end else begin
      r_err_ovf <= (wr_en & (|w_full)) | (r_err_ovf & ~err_clr);
      r_err_udf <= (rd_en & w_empty) | (r_err_udf & {CHANNELS{~err_clr}});
    end
  end

  assign err_ovf = r_err_ovf;
  assign err_udf = r_err_udf;
`endif

endmodule

// File: tb/tb_pea_fifo_bank.sv
// Scoreboard bench for pea_fifo_bank: stimulus queues expectations, a negedge monitor checks them.
module tb_pea_fifo_bank;
  localparam int DEPTH = 32;
  localparam int WIDTH = 32;
  localparam int CH    = 2;
  localparam int PW    = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [CH-1:0]     rd_en = '0;
  logic [CH*WIDTH-1:0] data_in = '0;
  logic [CH*PW-1:0]  population;
  logic [CH*PW-1:0]  free_space;
  logic [CH*WIDTH-1:0] data_out;
`ifdef PEA_FIFO_BANK_ERR_EN
  logic              err_clr = 1'b0;
  logic              err_ovf;
  logic [CH-1:0]     err_udf;
`endif

  pea_fifo_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CHANNELS(CH)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PEA_FIFO_BANK_ERR_EN
    .err_clr(err_clr),
    .err_ovf(err_ovf),
    .err_udf(err_udf),
`endif
    .wr_en(wr_en),
    .rd_en(rd_en),
    .data_in(data_in),
    .population(population),
    .free_space(free_space),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;   // 0 data_out, 1 population, 2 free_space, 3 err_ovf, 4 err_udf
    int          lane;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int lane, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s lane %0d at cycle %0d: got %0d, expected %0d", nm, lane, cyc, act, expv);
    end
  endtask

  function automatic logic [31:0] lane_data(input int l);
    return data_out[l*WIDTH +: WIDTH];
  endfunction
  function automatic logic [31:0] lane_pop(input int l);
    return 32'(population[l*PW +: PW]);
  endfunction
  function automatic logic [31:0] lane_free(input int l);
    return 32'(free_space[l*PW +: PW]);
  endfunction

  // Monitor: compares every expectation whose edge has already occurred.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        0: chk("data_out",   e.lane, lane_data(e.lane), e.val);
        1: chk("population", e.lane, lane_pop(e.lane),  e.val);
        2: chk("free_space", e.lane, lane_free(e.lane), e.val);
`ifdef PEA_FIFO_BANK_ERR_EN
        3: chk("err_ovf",    0, 32'(err_ovf), e.val);
        4: chk("err_udf",    0, 32'(err_udf), e.val);
`endif
        default: chk("bad_kind", e.lane, 32'(e.kind), 32'd0);
      endcase
    end
  end

  // Drive inputs for the next rising edge.
  task automatic drive(input logic w, input logic [1:0] r, input logic [31:0] d1, input logic [31:0] d0);
    @(posedge clk);
    #1;
    wr_en   = w;
    rd_en   = r;
    data_in = {d1, d0};
  endtask

  // Expect a value after the edge that the most recent drive() targets.
  task automatic expect_v(input int kind, input int lane, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc + 1;
    e.kind = kind;
    e.lane = lane;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic expect_pop(input logic [31:0] p0, input logic [31:0] p1);
    expect_v(1, 0, p0);
    expect_v(1, 1, p1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    for (int l = 0; l < CH; l++) begin
      chk("rst_pop",  l, lane_pop(l),  32'd0);
      chk("rst_free", l, lane_free(l), 32'd32);
      chk("rst_data", l, lane_data(l), 32'd0);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Single write then read on both lanes
    drive(1'b1, 2'b00, 32'd2, 32'd1);
    expect_pop(1, 1);
    expect_v(2, 0, 31);
    expect_v(2, 1, 31);
    drive(1'b0, 2'b11, 32'd0, 32'd0);
    expect_v(0, 0, 1);
    expect_v(0, 1, 2);
    expect_pop(0, 0);

    // Fill to full, overflow write dropped, drain in order
    for (int i = 0; i < 32; i++) drive(1'b1, 2'b00, 32'(i), 32'(i));
    expect_v(2, 0, 0);
    expect_v(2, 1, 0);
    expect_pop(32, 32);
    drive(1'b1, 2'b00, 32'd99, 32'd99);
    expect_pop(32, 32);
`ifdef PEA_FIFO_BANK_ERR_EN
    expect_v(3, 0, 1);
`endif
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 2'b11, 32'd0, 32'd0);
      expect_v(0, 0, 32'(i));
      expect_v(0, 1, 32'(i));
    end
    expect_pop(0, 0);
    expect_v(2, 0, 32);

    // Lane 0 drained while lane 1 full: writes are dropped
    for (int i = 0; i < 32; i++) drive(1'b1, 2'b00, 32'(100 + i), 32'(100 + i));
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 2'b01, 32'd0, 32'd0);
      expect_v(0, 0, 32'(100 + i));
    end
    expect_pop(0, 32);
    drive(1'b1, 2'b00, 32'd7, 32'd7);
    expect_pop(0, 32);
    drive(1'b1, 2'b10, 32'd7, 32'd7);
    expect_pop(0, 31);
    expect_v(0, 1, 100);
    for (int i = 0; i < 31; i++) begin
      drive(1'b0, 2'b10, 32'd0, 32'd0);
      expect_v(0, 1, 32'(101 + i));
    end
    expect_pop(0, 0);
    expect_v(0, 0, 131);

    // Read on empty lane 0 with a simultaneous write
    drive(1'b1, 2'b01, 32'd55, 32'd44);
    expect_v(0, 0, 131);
    expect_pop(1, 1);
`ifdef PEA_FIFO_BANK_ERR_EN
    expect_v(4, 0, 32'b01);
`endif
    drive(1'b0, 2'b11, 32'd0, 32'd0);
    expect_v(0, 0, 44);
    expect_v(0, 1, 55);
    expect_pop(0, 0);
`ifdef PEA_FIFO_BANK_ERR_EN
    // Clear while a new underflow on lane 1 occurs: the new event survives
    drive(1'b0, 2'b10, 32'd0, 32'd0);
    err_clr = 1'b1;
    expect_v(3, 0, 0);
    expect_v(4, 0, 32'b10);
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    err_clr = 1'b0;
`endif

    // Steady state at population 5 across pointer wrap
    for (int i = 0; i < 5; i++) drive(1'b1, 2'b00, 32'(1200 + i), 32'(200 + i));
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 2'b11, 32'(1205 + i), 32'(205 + i));
      expect_v(0, 0, 32'(200 + i));
      expect_v(0, 1, 32'(1200 + i));
      expect_v(1, 0, 5);
    end
    drive(1'b1, 2'b00, 32'd1245, 32'd245);
    drive(1'b1, 2'b00, 32'd1246, 32'd246);
    expect_pop(7, 7);
    drive(1'b0, 2'b00, 32'd0, 32'd0);

    // Asynchronous reset between edges
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    for (int l = 0; l < CH; l++) begin
      chk("arst_pop",  l, lane_pop(l),  32'd0);
      chk("arst_free", l, lane_free(l), 32'd32);
      chk("arst_data", l, lane_data(l), 32'd0);
    end
    #1 rst = 1'b1;

    // Normal operation after reset
    drive(1'b1, 2'b00, 32'd9, 32'd8);
    expect_pop(1, 1);
    drive(1'b0, 2'b11, 32'd0, 32'd0);
    expect_v(0, 0, 8);
    expect_v(0, 1, 9);
    expect_pop(0, 0);
    drive(1'b0, 2'b00, 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drain", 0, 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
